// File: rtl/pq_share_ctrl_if.sv
// pq_share_ctrl_if: bundles the requester, dequeue, PQ-datapath and status
// signals of pq_share_ctrl. The controller uses the slave modport. Client logic
// or a bench uses the master modport.
interface pq_share_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int KW    = 4,
    parameter int VW    = 4,
    parameter int DEPTH = 8
);
    localparam int DW = KW + VW;
    localparam int CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               deq_req;
    logic               deq_valid;
    logic [DW-1:0]      deq_data;
    logic [DW-1:0]      pq_idata;
    logic               pq_ivalid;
    logic               pq_ordy;
    logic [DW-1:0]      pq_odata;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    modport slave (
        input  req_valid, req_data, deq_req, pq_odata,
        output req_ready, deq_valid, deq_data, pq_idata, pq_ivalid, pq_ordy,
               count, full, empty
    );

    modport master (
        output req_valid, req_data, deq_req, pq_odata,
        input  req_ready, deq_valid, deq_data, pq_idata, pq_ivalid, pq_ordy,
               count, full, empty
    );
endinterface

// File: rtl/pq_share_ctrl.sv
// pq_share_ctrl: shares one shift-register priority queue among NREQ insert
// requesters and a single dequeue consumer.
// - Inserts are arbitrated one per cycle and reach the PQ as a registered
//   1-cycle ivalid strobe.
// - Pops are accepted while the queue is non-empty and reach the PQ as a
//   registered 1-cycle ordy strobe. The popped top entry is captured one
//   cycle later.
// - Occupancy is tracked so the PQ never overflows or underflows.
// Optional macro PQ_SHARE_FIXED_PRI_EN: fixed priority (lowest index wins)
// replaces the default round-robin arbiter and its pointer.
module pq_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int KW    = 4,
    parameter int VW    = 4,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    pq_share_ctrl_if.slave bus
);
    localparam int DW = KW + VW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Each request path is an implicit two-state machine: idle, or driving its
    // one-cycle PQ strobe. A new accept can re-enter STROBE back-to-back.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } strobe_state_t;

    strobe_state_t ins_state_q, ins_state_d;
    strobe_state_t pop_state_q, pop_state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] pq_idata_q, pq_idata_d;
    logic          deq_valid_q, deq_valid_d;
    logic [DW-1:0] deq_data_q, deq_data_d;

    logic [DW-1:0]   req_word [NREQ];
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            ins_acc;
    logic            pop_acc;
    logic            full;
    logic            empty;

    // Slice the flat request bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_word[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    // count_q already includes an insert whose strobe is in flight. The PQ
    // writes that entry on the same edge that ends the strobe, so a pop
    // accepted during the strobe only reaches the PQ afterwards. A pop can
    // therefore never target an entry that has not been written yet.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign pop_acc = !rst && bus.deq_req && !empty;

`ifdef PQ_SHARE_FIXED_PRI_EN
    // Fixed-priority grant: the lowest-indexed valid requester wins. The loop
    // scans downward so that the lowest index is the last one assigned.
    always_comb begin : grant_logic
        grant     = '0;
        grant_idx = '0;
        ins_acc   = 1'b0;
        if (!rst && !full) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (bus.req_valid[PW'(k)]) begin
                    ins_acc   = 1'b1;
                    grant_idx = PW'(k);
                end
            end
            if (ins_acc) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;

    // Round-robin grant: the first valid requester at or after the pointer
    // wins. The loop scans offsets downward so the smallest offset is the last
    // one assigned. The index wraps explicitly because NREQ need not be a
    // power of two.
    always_comb begin : grant_logic
        logic [PW:0] sum;
        grant     = '0;
        grant_idx = '0;
        ins_acc   = 1'b0;
        sum       = '0;
        if (!rst && !full) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                sum = {1'b0, ptr_q} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                if (bus.req_valid[sum[PW-1:0]]) begin
                    ins_acc   = 1'b1;
                    grant_idx = sum[PW-1:0];
                end
            end
            if (ins_acc) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    // Advance the pointer to the requester just after the winner.
    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (ins_acc) begin
            ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        end
    end
`endif

    // Next state for the strobes, the occupancy count and the returned data.
    always_comb begin : next_state
        ins_state_d = ins_acc ? ST_STROBE : ST_IDLE;
        pop_state_d = pop_acc ? ST_STROBE : ST_IDLE;
        count_d     = count_q;
        if (ins_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (!ins_acc && pop_acc) begin
            count_d = count_q - CW'(1);
        end
        pq_idata_d  = ins_acc ? req_word[grant_idx] : pq_idata_q;
        // The PQ shows the entry being removed during the ordy strobe.
        deq_valid_d = (pop_state_q == ST_STROBE);
        deq_data_d  = (pop_state_q == ST_STROBE) ? bus.pq_odata : deq_data_q;
    end

    // State registers. The reset also drops any insert or pop that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_state_q <= ST_IDLE;
            pop_state_q <= ST_IDLE;
            count_q     <= '0;
            pq_idata_q  <= '0;
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
`ifndef PQ_SHARE_FIXED_PRI_EN
            ptr_q       <= '0;
`endif
        end else begin
            ins_state_q <= ins_state_d;
            pop_state_q <= pop_state_d;
            count_q     <= count_d;
            pq_idata_q  <= pq_idata_d;
            deq_valid_q <= deq_valid_d;
            deq_data_q  <= deq_data_d;
`ifndef PQ_SHARE_FIXED_PRI_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.req_ready = grant;
    assign bus.pq_idata  = pq_idata_q;
    assign bus.pq_ivalid = (ins_state_q == ST_STROBE);
    assign bus.pq_ordy   = (pop_state_q == ST_STROBE);
    assign bus.deq_valid = deq_valid_q;
    assign bus.deq_data  = deq_data_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
endmodule

// File: tb/tb_pq_share_ctrl.sv
// tb_pq_share_ctrl: bench for pq_share_ctrl.
// A behavioural min-key priority queue stands in for the PQ instance. Its
// ordering is stable for equal keys. Expected PQ inserts and dequeue results
// are pushed to a scoreboard queue when the stimulus is driven. They are popped
// and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_pq_share_ctrl;
    localparam int NREQ  = 4;
    localparam int KW    = 4;
    localparam int VW    = 4;
    localparam int DEPTH = 8;
    localparam int DW    = KW + VW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] exp_q[$];

    pq_share_ctrl_if #(.NREQ(NREQ), .KW(KW), .VW(VW), .DEPTH(DEPTH)) bus();

    pq_share_ctrl #(.NREQ(NREQ), .KW(KW), .VW(VW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural PQ: remove the top entry on ordy, then insert in key order on ivalid.
    logic [DW-1:0] pq_mem[$];
    logic [DW-1:0] pq_top;
    assign bus.pq_odata = pq_top;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pq_mem.delete();
            pq_top <= '0;
        end else begin
            if (bus.pq_ordy) begin
                checks++;
                if (pq_mem.size() == 0) begin
                    errors++;
                    $display("FAIL pq_underflow: ordy with size=%0d required size>0", pq_mem.size());
                end else begin
                    void'(pq_mem.pop_front());
                end
            end
            if (bus.pq_ivalid) begin
                int pos;
                checks++;
                if (pq_mem.size() >= DEPTH) begin
                    errors++;
                    $display("FAIL pq_overflow: ivalid with size=%0d required size<%0d", pq_mem.size(), DEPTH);
                end else begin
                    pos = pq_mem.size();
                    for (int i = 0; i < pq_mem.size(); i++) begin
                        if (pos == pq_mem.size() && pq_mem[i][DW-1:VW] > bus.pq_idata[DW-1:VW]) begin
                            pos = i;
                        end
                    end
                    pq_mem.insert(pos, bus.pq_idata);
                end
            end
            pq_top <= (pq_mem.size() > 0) ? pq_mem[0] : '0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.deq_req   = 1'b0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Present one entry on requester i and hold it until it is granted.
    // Returns at the start of that insert's strobe cycle.
    task automatic insert_one(input int i, input logic [DW-1:0] d);
        bit granted;
        granted = 1'b0;
        bus.req_data[i*DW +: DW] = d;
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !granted; n++) begin
            sample();
            if (bus.req_ready[i]) granted = 1'b1;
            next_cycle();
        end
        bus.req_valid[i] = 1'b0;
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL insert_timeout: req %0d not granted within 20 cycles, required a grant", i);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = '1;
        bus.deq_req   = 1'b1;
        sample();
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL por_req_ready: got %b required 0000", bus.req_ready); end
        checks++; if (bus.pq_ivalid !== 1'b0) begin errors++; $display("FAIL por_pq_ivalid: got %b required 0", bus.pq_ivalid); end
        checks++; if (bus.pq_ordy !== 1'b0) begin errors++; $display("FAIL por_pq_ordy: got %b required 0", bus.pq_ordy); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL por_count: got %0d required 0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL por_flags: got empty=%b full=%b required 1/0", bus.empty, bus.full); end
        $display("reset: power-on state checked");
        apply_reset();
    endtask

    task automatic test_reset_mid_insert();
        apply_reset();
        bus.req_data[DW-1:0] = 8'h77;
        bus.req_valid = 4'b0001;
        next_cycle();
        bus.req_valid = 4'b1111;
        checks++; if (bus.pq_ivalid !== 1'b1) begin errors++; $display("FAIL rst_pre_ivalid: got %b required 1", bus.pq_ivalid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b required 0000", bus.req_ready); end
        checks++; if (bus.pq_ivalid !== 1'b0) begin errors++; $display("FAIL rst_pq_ivalid: got %b required 0", bus.pq_ivalid); end
        checks++; if (bus.pq_idata !== 8'h00) begin errors++; $display("FAIL rst_pq_idata: got %h required 00", bus.pq_idata); end
        checks++; if (bus.pq_ordy !== 1'b0 || bus.deq_valid !== 1'b0) begin errors++; $display("FAIL rst_strobes: got ordy=%b deq_valid=%b required 0/0", bus.pq_ordy, bus.deq_valid); end
        checks++; if (bus.deq_data !== 8'h00) begin errors++; $display("FAIL rst_deq_data: got %h required 00", bus.deq_data); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_flags: got empty=%b full=%b required 1/0", bus.empty, bus.full); end
        $display("reset: mid-insert reset checked");
        next_cycle();
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_rr_fill();
        int exp_g;
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = {4'(i), 4'(10 + i)};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < DEPTH; k++) begin
`ifdef PQ_SHARE_FIXED_PRI_EN
            exp_g = 0;
`else
            exp_g = k % NREQ;
`endif
            sample();
            checks++; if (bus.req_ready !== 4'(1 << exp_g)) begin errors++; $display("FAIL rr_grant%0d: got %b required %b", k, bus.req_ready, 4'(1 << exp_g)); end
            checks++; if (bus.count !== 4'(k)) begin errors++; $display("FAIL rr_count%0d: got %0d required %0d", k, bus.count, k); end
            exp_q.push_back({4'(exp_g), 4'(10 + exp_g)});
            next_cycle();
            exp_d = exp_q.pop_front();
            checks++; if (bus.pq_ivalid !== 1'b1 || bus.pq_idata !== exp_d) begin errors++; $display("FAIL rr_strobe%0d: got ivalid=%b idata=%h required 1/%h", k, bus.pq_ivalid, bus.pq_idata, exp_d); end
            $display("insert: grant=%b idata=%h", 4'(1 << exp_g), bus.pq_idata);
        end
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++; if (bus.req_ready !== 4'b0000 || bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL rr_full%0d: got ready=%b full=%b count=%0d required 0000/1/8", k, bus.req_ready, bus.full, bus.count); end
            next_cycle();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_pop_sequence();
        int n_ordy, n_valid, first_valid;
        logic [DW-1:0] exp_d;
        apply_reset();
        insert_one(0, 8'h4E);
        insert_one(0, 8'hCC);
        insert_one(0, 8'h3D);
        insert_one(0, 8'h1B);
        next_cycle();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'h4E);
        exp_q.push_back(8'hCC);
        n_ordy = 0; n_valid = 0; first_valid = -1;
        for (int n = 0; n < 8; n++) begin
            bus.deq_req = (n < 5);
            sample();
            checks++; if (bus.count !== 4'((n < 4) ? 4 - n : 0)) begin errors++; $display("FAIL pop_count%0d: got %0d required %0d", n, bus.count, (n < 4) ? 4 - n : 0); end
            if (bus.pq_ordy === 1'b1) n_ordy++;
            if (bus.deq_valid === 1'b1) begin
                if (first_valid < 0) first_valid = n;
                n_valid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL pop_extra: got deq_data=%h required no deq_valid", bus.deq_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (bus.deq_data !== exp_d) begin errors++; $display("FAIL pop_data: got %h required %h", bus.deq_data, exp_d); end
                end
                $display("dequeue: data=%h", bus.deq_data);
            end
            next_cycle();
        end
        bus.deq_req = 1'b0;
        checks++; if (n_ordy != 4) begin errors++; $display("FAIL pop_ordy_count: got %0d required 4", n_ordy); end
        checks++; if (n_valid != 4) begin errors++; $display("FAIL pop_valid_count: got %0d required 4", n_valid); end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL pop_latency: got first deq_valid at %0d required 2", first_valid); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pop_empty: got %b required 1", bus.empty); end
    endtask

    task automatic test_insert_then_pop();
        logic [DW-1:0] exp_d;
        apply_reset();
        bus.req_data[2*DW-1:DW] = 8'h5F;
        bus.req_valid = 4'b0010;
        bus.deq_req = 1'b1;
        sample();
        checks++; if (bus.req_ready !== 4'b0010 || bus.empty !== 1'b1) begin errors++; $display("FAIL ip_accept: got ready=%b empty=%b required 0010/1", bus.req_ready, bus.empty); end
        next_cycle();
        bus.req_valid = '0;
        sample();
        checks++; if (bus.pq_ordy !== 1'b0 || bus.pq_ivalid !== 1'b1) begin errors++; $display("FAIL ip_no_early_pop: got ordy=%b ivalid=%b required 0/1", bus.pq_ordy, bus.pq_ivalid); end
        checks++; if (bus.empty !== 1'b0 || bus.count !== 4'd1) begin errors++; $display("FAIL ip_occupancy: got empty=%b count=%0d required 0/1", bus.empty, bus.count); end
        exp_q.push_back(8'h5F);
        next_cycle();
        bus.deq_req = 1'b0;
        sample();
        checks++; if (bus.pq_ordy !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL ip_pop: got ordy=%b count=%0d required 1/0", bus.pq_ordy, bus.count); end
        next_cycle();
        sample();
        exp_d = exp_q.pop_front();
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== exp_d) begin errors++; $display("FAIL ip_deq: got valid=%b data=%h required 1/%h", bus.deq_valid, bus.deq_data, exp_d); end
        $display("dequeue: data=%h", bus.deq_data);
        next_cycle();
        sample();
        checks++; if (bus.deq_valid !== 1'b0 || bus.pq_ordy !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL ip_idle: got valid=%b ordy=%b count=%0d required 0/0/0", bus.deq_valid, bus.pq_ordy, bus.count); end
        next_cycle();
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] exp_d;
        apply_reset();
        insert_one(0, 8'h2C);
        insert_one(0, 8'h66);
        insert_one(0, 8'h99);
        next_cycle();
        bus.req_data[3*DW-1:2*DW] = 8'h1B;
        bus.req_valid = 4'b0100;
        bus.deq_req = 1'b1;
        sample();
        checks++; if (bus.req_ready !== 4'b0100 || bus.count !== 4'd3) begin errors++; $display("FAIL cc_accept: got ready=%b count=%0d required 0100/3", bus.req_ready, bus.count); end
        exp_q.push_back(8'h2C);
        next_cycle();
        bus.req_valid = '0;
        bus.deq_req = 1'b0;
        sample();
        checks++; if (bus.pq_ivalid !== 1'b1 || bus.pq_ordy !== 1'b1) begin errors++; $display("FAIL cc_strobes: got ivalid=%b ordy=%b required 1/1", bus.pq_ivalid, bus.pq_ordy); end
        checks++; if (bus.count !== 4'd3 || bus.pq_idata !== 8'h1B) begin errors++; $display("FAIL cc_count: got count=%0d idata=%h required 3/1b", bus.count, bus.pq_idata); end
        next_cycle();
        bus.deq_req = 1'b1;
        exp_q.push_back(8'h1B);
        sample();
        exp_d = exp_q.pop_front();
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== exp_d) begin errors++; $display("FAIL cc_deq_old_top: got valid=%b data=%h required 1/%h", bus.deq_valid, bus.deq_data, exp_d); end
        $display("dequeue: data=%h", bus.deq_data);
        next_cycle();
        bus.deq_req = 1'b0;
        next_cycle();
        sample();
        exp_d = exp_q.pop_front();
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== exp_d) begin errors++; $display("FAIL cc_deq_new_top: got valid=%b data=%h required 1/%h", bus.deq_valid, bus.deq_data, exp_d); end
        $display("dequeue: data=%h", bus.deq_data);
        next_cycle();
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int k = 0; k < DEPTH; k++) insert_one(0, {4'(k), 4'(k)});
        next_cycle();
        bus.req_data[DW-1:0] = 8'hF0;
        bus.req_valid = 4'b0001;
        bus.deq_req = 1'b1;
        sample();
        checks++; if (bus.req_ready !== 4'b0000 || bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL fp_blocked: got ready=%b full=%b count=%0d required 0000/1/8", bus.req_ready, bus.full, bus.count); end
        exp_q.push_back(8'h00);
        next_cycle();
        bus.deq_req = 1'b0;
        sample();
        checks++; if (bus.pq_ordy !== 1'b1 || bus.pq_ivalid !== 1'b0 || bus.count !== 4'd7) begin errors++; $display("FAIL fp_pop_only: got ordy=%b ivalid=%b count=%0d required 1/0/7", bus.pq_ordy, bus.pq_ivalid, bus.count); end
        checks++; if (bus.req_ready !== 4'b0001 || bus.full !== 1'b0) begin errors++; $display("FAIL fp_regrant: got ready=%b full=%b required 0001/0", bus.req_ready, bus.full); end
        next_cycle();
        bus.req_valid = '0;
        sample();
        checks++; if (bus.pq_ivalid !== 1'b1 || bus.pq_idata !== 8'hF0 || bus.count !== 4'd8 || bus.full !== 1'b1) begin errors++; $display("FAIL fp_refill: got ivalid=%b idata=%h count=%0d full=%b required 1/f0/8/1", bus.pq_ivalid, bus.pq_idata, bus.count, bus.full); end
        exp_d = exp_q.pop_front();
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== exp_d) begin errors++; $display("FAIL fp_deq: got valid=%b data=%h required 1/%h", bus.deq_valid, bus.deq_data, exp_d); end
        $display("dequeue: data=%h", bus.deq_data);
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_insert();
        test_rr_fill();
        test_pop_sequence();
        test_insert_then_pop();
        test_concurrent();
        test_full_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
